// File: rtl/de_hazard_unit.sv
// LC-3b decode-stage hazard/issue controller: in-order in-flight table for
// RAW register and NZP hazards, downstream stall, branch flush, stall counter.
module de_hazard_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_valid,
  input  logic [2:0]  de_sr1,
  input  logic [2:0]  de_sr2,
  input  logic        de_sr1_used,
  input  logic        de_sr2_used,
  input  logic        de_uses_cc,
  input  logic        de_dr_we,
  input  logic [2:0]  de_dr,
  input  logic        de_sets_cc,
  input  logic        agex_stall,
  input  logic        wb_retire,
  input  logic        flush,
  input  logic [1:0]  flush_keep,
  output logic        load_agex,
  output logic        agex_bubble,
  output logic        de_stall,
  output logic [15:0] stall_cycles
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, REFILL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [DEPTH-1:0] ent_we_q, ent_we_d;
  logic [DEPTH-1:0] ent_cc_q, ent_cc_d;
  logic [2:0]       ent_dr_q [DEPTH];
  logic [2:0]       ent_dr_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      stall_cycles_q, stall_cycles_d;

  logic [DEPTH-1:0] match;
  logic             hazard, full, issue, pop;
  logic [CW-1:0]    cnt_after_pop, keep;

  // Entry 0 is always the oldest; the table is compacted on every pop.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = ent_valid_q[gi] &
        ((ent_we_q[gi] & ((de_sr1_used & (ent_dr_q[gi] == de_sr1)) |
                          (de_sr2_used & (ent_dr_q[gi] == de_sr2)))) |
         (ent_cc_q[gi] & de_uses_cc));
    end
  endgenerate

  assign hazard = de_valid & (|match);
  assign full   = (count_q == CW'(DEPTH)) & ~wb_retire;
  assign issue  = (state_q != REFILL) & de_valid & ~hazard & ~full &
                  ~agex_stall & ~flush;
  assign pop    = wb_retire & (count_q != '0);

  assign load_agex    = ~agex_stall;
  assign agex_bubble  = ~issue;
  assign de_stall     = de_valid & ~issue & ~flush & (state_q != REFILL);
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = REFILL;
    else if (state_q == REFILL)
      state_d = RUN;
    else if (hazard | full | agex_stall)
      state_d = STALL;
    else
      state_d = RUN;
  end

  always_comb begin
    ent_valid_d   = ent_valid_q;
    ent_we_d      = ent_we_q;
    ent_cc_d      = ent_cc_q;
    ent_dr_d      = ent_dr_q;
    cnt_after_pop = count_q - CW'(pop);
    count_d       = cnt_after_pop;
    keep          = CW'(flush_keep);

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_valid_d[i] = ent_valid_q[i+1];
        ent_we_d[i]    = ent_we_q[i+1];
        ent_cc_d[i]    = ent_cc_q[i+1];
        ent_dr_d[i]    = ent_dr_q[i+1];
      end
      ent_valid_d[DEPTH-1] = 1'b0;
    end

    // Truncation acts on the post-pop table; issue is already blocked by flush.
    if (flush) begin
      if (keep > cnt_after_pop)
        keep = cnt_after_pop;
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) >= keep)
          ent_valid_d[i] = 1'b0;
      count_d = keep;
    end else if (issue) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_after_pop) begin
          ent_valid_d[i] = 1'b1;
          ent_we_d[i]    = de_dr_we;
          ent_cc_d[i]    = de_sets_cc;
          ent_dr_d[i]    = de_dr;
        end
      end
      count_d = cnt_after_pop + CW'(1);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (de_stall && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      ent_valid_q    <= '0;
      ent_we_q       <= '0;
      ent_cc_q       <= '0;
      count_q        <= '0;
      stall_cycles_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_dr_q[i] <= 3'd0;
    end else begin
      state_q        <= state_d;
      ent_valid_q    <= ent_valid_d;
      ent_we_q       <= ent_we_d;
      ent_cc_q       <= ent_cc_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
      for (int i = 0; i < DEPTH; i++)
        ent_dr_q[i] <= ent_dr_d[i];
    end
  end

endmodule
